// File: rtl/turbo_codec_scheduler.sv
// Round-robin scheduler sharing one turbo codec core between an encode and a decode requester.
// Optional TURBO_SCHED_STATS_EN adds saturating job/timeout counters.
module turbo_codec_scheduler #(
  parameter int unsigned BLOCK_LEN = 8,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enc_req,
  input  logic [BLOCK_LEN-1:0] enc_block,
  output logic                 enc_gnt,
  input  logic                 dec_req,
  input  logic [2:0]           dec_sym,
  output logic                 dec_gnt,
  output logic                 core_start,
  output logic                 core_mode,
  output logic                 core_data,
  output logic [2:0]           core_sym,
  input  logic                 core_valid,
  input  logic [2:0]           core_enc,
  input  logic                 core_dec,
  output logic                 rsp_valid,
  output logic                 rsp_mode,
  output logic [2:0]           rsp_data,
  output logic                 rsp_timeout,
`ifdef TURBO_SCHED_STATS_EN
  output logic [7:0]           stat_enc,
  output logic [7:0]           stat_dec,
  output logic [7:0]           stat_tmo,
`endif
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(BLOCK_LEN);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LAUNCH = 3'd1;
  localparam logic [2:0] FEED   = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  logic [2:0]           state, state_nxt;
  logic [BLOCK_LEN-1:0] payload, payload_nxt;
  logic [2:0]           sym, sym_nxt;
  logic                 mode, mode_nxt;
  logic                 last_enc, last_enc_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_nxt;
  logic                 enc_win;
  logic [IDX_W-1:0]     idx_inc;

  logic       enc_gnt_nxt, dec_gnt_nxt, core_start_nxt, core_mode_nxt, core_data_nxt;
  logic [2:0] core_sym_nxt, rsp_data_nxt;
  logic       rsp_valid_nxt, rsp_mode_nxt, rsp_timeout_nxt, busy_nxt;

  // Tie goes to whichever requester did not win last.
  assign enc_win = enc_req & (~dec_req | ~last_enc);
  assign idx_inc = bit_idx + IDX_W'(1);

  // Next state plus next value of every registered output.
  always_comb begin
    state_nxt       = state;
    payload_nxt     = payload;
    sym_nxt         = sym;
    mode_nxt        = mode;
    last_enc_nxt    = last_enc;
    bit_idx_nxt     = bit_idx;
    tmo_cnt_nxt     = tmo_cnt;
    enc_gnt_nxt     = 1'b0;
    dec_gnt_nxt     = 1'b0;
    core_start_nxt  = 1'b0;
    core_mode_nxt   = 1'b0;
    core_data_nxt   = 1'b0;
    core_sym_nxt    = 3'b000;
    rsp_valid_nxt   = 1'b0;
    rsp_mode_nxt    = 1'b0;
    rsp_data_nxt    = 3'b000;
    rsp_timeout_nxt = 1'b0;
    busy_nxt        = 1'b0;
    case (state)
      IDLE: begin
        if (enc_req || dec_req) begin
          state_nxt      = LAUNCH;
          mode_nxt       = enc_win;
          last_enc_nxt   = enc_win;
          payload_nxt    = enc_win ? enc_block : '0;
          sym_nxt        = enc_win ? 3'b000 : dec_sym;
          enc_gnt_nxt    = enc_win;
          dec_gnt_nxt    = ~enc_win;
          core_start_nxt = 1'b1;
          core_mode_nxt  = enc_win;
          core_data_nxt  = enc_win & enc_block[0];
          core_sym_nxt   = enc_win ? 3'b000 : dec_sym;
          busy_nxt       = 1'b1;
        end
      end
      LAUNCH: begin
        busy_nxt      = 1'b1;
        core_mode_nxt = mode;
        if (mode) begin
          state_nxt     = FEED;
          bit_idx_nxt   = IDX_W'(1);
          core_data_nxt = payload[1];
        end else begin
          state_nxt   = WAIT;
          tmo_cnt_nxt = '0;
        end
      end
      FEED: begin
        busy_nxt      = 1'b1;
        core_mode_nxt = mode;
        if (bit_idx == IDX_W'(BLOCK_LEN - 1)) begin
          state_nxt   = WAIT;
          tmo_cnt_nxt = '0;
        end else begin
          bit_idx_nxt   = idx_inc;
          core_data_nxt = payload[idx_inc];
        end
      end
      WAIT: begin
        busy_nxt      = 1'b1;
        core_mode_nxt = mode;
        if (core_valid) begin
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
          rsp_mode_nxt  = mode;
          rsp_data_nxt  = mode ? core_enc : {2'b00, core_dec};
        end else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
          // Response lands TIMEOUT+1 cycles after WAIT entry.
          state_nxt       = RESP;
          rsp_valid_nxt   = 1'b1;
          rsp_mode_nxt    = mode;
          rsp_timeout_nxt = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      payload     <= '0;
      sym         <= 3'b000;
      mode        <= 1'b0;
      last_enc    <= 1'b0;
      bit_idx     <= '0;
      tmo_cnt     <= '0;
      enc_gnt     <= 1'b0;
      dec_gnt     <= 1'b0;
      core_start  <= 1'b0;
      core_mode   <= 1'b0;
      core_data   <= 1'b0;
      core_sym    <= 3'b000;
      rsp_valid   <= 1'b0;
      rsp_mode    <= 1'b0;
      rsp_data    <= 3'b000;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      payload     <= payload_nxt;
      sym         <= sym_nxt;
      mode        <= mode_nxt;
      last_enc    <= last_enc_nxt;
      bit_idx     <= bit_idx_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      enc_gnt     <= enc_gnt_nxt;
      dec_gnt     <= dec_gnt_nxt;
      core_start  <= core_start_nxt;
      core_mode   <= core_mode_nxt;
      core_data   <= core_data_nxt;
      core_sym    <= core_sym_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_mode    <= rsp_mode_nxt;
      rsp_data    <= rsp_data_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      busy        <= busy_nxt;
    end
  end

`ifdef TURBO_SCHED_STATS_EN
  // Saturating job counters, updated from the registered response in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_enc <= 8'd0;
      stat_dec <= 8'd0;
      stat_tmo <= 8'd0;
    end else if (state == RESP) begin
      if (rsp_timeout) begin
        if (stat_tmo != 8'hFF) stat_tmo <= stat_tmo + 8'd1;
      end else if (rsp_mode) begin
        if (stat_enc != 8'hFF) stat_enc <= stat_enc + 8'd1;
      end else begin
        if (stat_dec != 8'hFF) stat_dec <= stat_dec + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_turbo_codec_scheduler.sv
// Directed self-checking bench for turbo_codec_scheduler (BLOCK_LEN=8, TIMEOUT=15).
module tb_turbo_codec_scheduler;

  logic       clk, reset;
  logic       enc_req, dec_req;
  logic [7:0] enc_block;
  logic [2:0] dec_sym;
  logic       enc_gnt, dec_gnt;
  logic       core_start, core_mode, core_data;
  logic [2:0] core_sym;
  logic       core_valid;
  logic [2:0] core_enc;
  logic       core_dec;
  logic       rsp_valid, rsp_mode, rsp_timeout, busy;
  logic [2:0] rsp_data;
`ifdef TURBO_SCHED_STATS_EN
  logic [7:0] stat_enc, stat_dec, stat_tmo;
`endif

  int errors = 0;
  int checks = 0;

  turbo_codec_scheduler #(.BLOCK_LEN(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .enc_req(enc_req), .enc_block(enc_block), .enc_gnt(enc_gnt),
    .dec_req(dec_req), .dec_sym(dec_sym), .dec_gnt(dec_gnt),
    .core_start(core_start), .core_mode(core_mode), .core_data(core_data), .core_sym(core_sym),
    .core_valid(core_valid), .core_enc(core_enc), .core_dec(core_dec),
    .rsp_valid(rsp_valid), .rsp_mode(rsp_mode), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
`ifdef TURBO_SCHED_STATS_EN
    .stat_enc(stat_enc), .stat_dec(stat_dec), .stat_tmo(stat_tmo),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({enc_gnt, dec_gnt, core_start, core_mode, core_data, core_sym, rsp_valid, rsp_mode,
         rsp_data, rsp_timeout, busy} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b%b start=%b mode=%b data=%b sym=%b rsp=%b busy=%b want all 0",
               enc_gnt, dec_gnt, core_start, core_mode, core_data, core_sym, rsp_valid, busy);
    end
`ifdef TURBO_SCHED_STATS_EN
    checks++;
    if ({stat_enc, stat_dec, stat_tmo} !== 24'd0) begin
      errors++;
      $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", stat_enc, stat_dec, stat_tmo);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_encode();
    logic [7:0] blk;
    blk = 8'hA5;
    enc_block = blk;
    enc_req = 1'b1;
    step();  // cycle 1
    checks++;
    if (enc_gnt !== 1'b1 || dec_gnt !== 1'b0) begin
      errors++;
      $display("FAIL enc_grant: got enc_gnt=%b dec_gnt=%b want 1/0", enc_gnt, dec_gnt);
    end
    checks++;
    if (core_start !== 1'b1 || core_mode !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL enc_launch: got start=%b mode=%b busy=%b want 1/1/1", core_start, core_mode, busy);
    end
    enc_req = 1'b0;
    enc_block = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) step();
      checks++;
      if (core_data !== blk[c-1]) begin
        errors++;
        $display("FAIL enc_feed_bit%0d: got core_data=%b want %b", c - 1, core_data, blk[c-1]);
      end
    end
    step();  // cycle 9: WAIT
    checks++;
    if (core_start !== 1'b0 || core_data !== 1'b0 || core_mode !== 1'b1 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL enc_wait: got start=%b data=%b mode=%b busy=%b rsp=%b want 0/0/1/1/0",
               core_start, core_data, core_mode, busy, rsp_valid);
    end
    step();  // 10
    step();  // 11
    core_valid = 1'b1;
    core_enc = 3'b101;
    step();  // 12
    core_valid = 1'b0;
    core_enc = 3'b000;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_mode !== 1'b1 || rsp_data !== 3'b101 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL enc_rsp: got valid=%b mode=%b data=%b tmo=%b want 1/1/101/0",
               rsp_valid, rsp_mode, rsp_data, rsp_timeout);
    end
    step();  // 13: IDLE
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || core_mode !== 1'b0) begin
      errors++;
      $display("FAIL enc_idle: got busy=%b rsp=%b mode=%b want 0/0/0", busy, rsp_valid, core_mode);
    end
  endtask

  task automatic test_decode();
    dec_sym = 3'b011;
    dec_req = 1'b1;
    step();  // cycle 1
    checks++;
    if (dec_gnt !== 1'b1 || enc_gnt !== 1'b0 || core_start !== 1'b1 || core_sym !== 3'b011 || core_mode !== 1'b0) begin
      errors++;
      $display("FAIL dec_launch: got dec_gnt=%b enc_gnt=%b start=%b sym=%b mode=%b want 1/0/1/011/0",
               dec_gnt, enc_gnt, core_start, core_sym, core_mode);
    end
    dec_req = 1'b0;
    dec_sym = 3'b111;
    step();  // 2: WAIT
    checks++;
    if (core_start !== 1'b0 || core_sym !== 3'b000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dec_wait: got start=%b sym=%b busy=%b want 0/000/1", core_start, core_sym, busy);
    end
    for (int c = 3; c <= 6; c++) step();
    core_valid = 1'b1;
    core_dec = 1'b1;
    core_enc = 3'b110;
    step();  // 7
    core_valid = 1'b0;
    core_dec = 1'b0;
    core_enc = 3'b000;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_mode !== 1'b0 || rsp_data !== 3'b001 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL dec_rsp: got valid=%b mode=%b data=%b tmo=%b want 1/0/001/0",
               rsp_valid, rsp_mode, rsp_data, rsp_timeout);
    end
    step();  // 8
  endtask

  task automatic test_tie();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    enc_block = 8'h01;
    dec_sym = 3'b010;
    core_valid = 1'b1;
    core_enc = 3'b011;
    enc_req = 1'b1;
    dec_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (enc_gnt || dec_gnt) break;
    end
    checks++;
    if (enc_gnt !== 1'b1 || dec_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie_first: got enc_gnt=%b dec_gnt=%b want 1/0", enc_gnt, dec_gnt);
    end
    enc_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (enc_gnt || dec_gnt) break;
    end
    checks++;
    if (dec_gnt !== 1'b1 || enc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie_second: got enc_gnt=%b dec_gnt=%b want 0/1", enc_gnt, dec_gnt);
    end
    dec_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy) break;
    end
    enc_req = 1'b1;
    dec_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (enc_gnt || dec_gnt) break;
    end
    checks++;
    if (enc_gnt !== 1'b1 || dec_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie_third: got enc_gnt=%b dec_gnt=%b want 1/0", enc_gnt, dec_gnt);
    end
    enc_req = 1'b0;
    dec_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy) break;
    end
    core_valid = 1'b0;
    core_enc = 3'b000;
  endtask

  task automatic test_valid_in_feed();
    logic seen;
    seen = 1'b0;
    enc_block = 8'h3C;
    enc_req = 1'b1;
    step();  // 1
    enc_req = 1'b0;
    for (int c = 2; c <= 4; c++) step();
    core_valid = 1'b1;
    core_enc = 3'b111;
    step();  // 5
    core_valid = 1'b0;
    core_enc = 3'b000;
    if (rsp_valid !== 1'b0) seen = 1'b1;
    for (int c = 6; c <= 11; c++) begin
      step();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL feed_valid_ignored: got early_rsp=%b busy=%b want 0/1", seen, busy);
    end
    core_valid = 1'b1;
    core_enc = 3'b010;
    step();  // 12
    core_valid = 1'b0;
    core_enc = 3'b000;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_mode !== 1'b1 || rsp_data !== 3'b010) begin
      errors++;
      $display("FAIL feed_valid_rsp: got valid=%b mode=%b data=%b want 1/1/010", rsp_valid, rsp_mode, rsp_data);
    end
    step();  // 13
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    dec_sym = 3'b110;
    dec_req = 1'b1;
    step();  // 1
    dec_req = 1'b0;
    core_dec = 1'b1;
    core_enc = 3'b111;
    for (int c = 2; c <= 17; c++) begin
      step();
      if (rsp_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: got rsp_valid before cycle 18, want none");
    end
    step();  // 18 = WAIT entry (2) + 16
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_data !== 3'b000 || rsp_mode !== 1'b0) begin
      errors++;
      $display("FAIL tmo_rsp: got valid=%b tmo=%b data=%b mode=%b want 1/1/000/0",
               rsp_valid, rsp_timeout, rsp_data, rsp_mode);
    end
    core_dec = 1'b0;
    core_enc = 3'b000;
    step();  // 19
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle: got busy=%b rsp=%b tmo=%b want 0/0/0", busy, rsp_valid, rsp_timeout);
    end
`ifdef TURBO_SCHED_STATS_EN
    checks++;
    if (stat_enc !== 8'd3 || stat_dec !== 8'd1 || stat_tmo !== 8'd1) begin
      errors++;
      $display("FAIL stats: got enc=%0d dec=%0d tmo=%0d want 3/1/1", stat_enc, stat_dec, stat_tmo);
    end
`endif
  endtask

  task automatic test_reset_in_feed();
    logic stray;
    stray = 1'b0;
    enc_block = 8'hFF;
    enc_req = 1'b1;
    step();  // 1
    enc_req = 1'b0;
    for (int c = 2; c <= 4; c++) step();
    reset = 1'b1;
    step();  // 5
    checks++;
    if ({enc_gnt, dec_gnt, core_start, core_mode, core_data, core_sym, rsp_valid, rsp_mode,
         rsp_data, rsp_timeout, busy} !== 14'd0) begin
      errors++;
      $display("FAIL feed_reset: got data=%b mode=%b busy=%b rsp=%b want all outputs 0",
               core_data, core_mode, busy, rsp_valid);
    end
    reset = 1'b0;
    core_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL feed_reset_abort: got stray rsp/busy=%b want 0", stray);
    end
    enc_req = 1'b1;
    dec_req = 1'b1;
    step();
    checks++;
    if (enc_gnt !== 1'b1 || dec_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_tie: got enc_gnt=%b dec_gnt=%b want 1/0", enc_gnt, dec_gnt);
    end
    enc_req = 1'b0;
    dec_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy) break;
    end
    core_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    enc_req = 1'b0;
    dec_req = 1'b0;
    enc_block = 8'h00;
    dec_sym = 3'b000;
    core_valid = 1'b0;
    core_enc = 3'b000;
    core_dec = 1'b0;
    test_reset();
    test_encode();
    test_decode();
    test_tie();
    test_valid_in_feed();
    test_timeout();
    test_reset_in_feed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
